// File: rtl/lbp_image_host.sv
// lbp_image_host
//   Image-side responder for the LBP engine. It holds the gray image and serves
//   the engine's combinational reads. It captures the engine's result writes into
//   a result store and tracks the end of each run. The host loads the image
//   before a run and reads the results back after it.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start               host pulse; begins an image load from IDLE or DONE
//   ld_valid/addr/data  host image write beat; ld_last marks the final beat
//   gray_ready          image available to the engine (registered)
//   gray_req/addr/data  engine image read; gray_data is combinational
//   lbp_valid/addr/data engine result write
//   finish              engine completion level
//   done                run complete, results readable (registered)
//   wr_cnt              result writes captured this run (saturating)
//   proto_err           sticky protocol-violation flag, cleared by start
//   rd_addr/rd_data     host result readback, 1-cycle latency
module lbp_image_host #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              done,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              proto_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t state;

    logic [DATA_W-1:0] img [0:DEPTH-1];
    logic [DATA_W-1:0] res [0:DEPTH-1];

    logic start_ok;
    logic img_we;
    logic res_we;
    logic violation;

    always_comb begin
        start_ok  = start && (state == IDLE || state == DONE);
        img_we    = ld_valid && (state == LOAD);
        res_we    = lbp_valid && (state == SERVE);
        violation = ((gray_req || lbp_valid) && state != SERVE)
                 || (ld_valid && state != LOAD)
                 || (start && !(state == IDLE || state == DONE));
    end

    // Engine samples gray_data on the same edge it presents gray_addr.
    always_comb begin
        gray_data = '0;
        if (gray_req) begin
            gray_data = img[gray_addr];
        end
    end

    // Memories are never cleared, so they live outside the reset domain.
    always_ff @(posedge clk) begin
        if (img_we) begin
            img[ld_addr] <= ld_data;
        end
        if (res_we) begin
            res[lbp_addr] <= lbp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gray_ready <= 1'b0;
            done       <= 1'b0;
            wr_cnt     <= '0;
            proto_err  <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_data <= res[rd_addr];

            // An accepted start clears the flag, but a violation seen in the
            // same cycle still wins.
            if (start_ok) begin
                proto_err <= violation;
            end else if (violation) begin
                proto_err <= 1'b1;
            end

            if (res_we && wr_cnt != CNT_MAX) begin
                wr_cnt <= wr_cnt + 1'b1;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state  <= LOAD;
                        done   <= 1'b0;
                        wr_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid && ld_last) begin
                        state      <= SERVE;
                        gray_ready <= 1'b1;
                    end
                end
                SERVE: begin
                    if (finish) begin
                        state      <= DONE;
                        gray_ready <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_image_host.sv
// tb_lbp_image_host
//   Self-checking bench for lbp_image_host: table-driven image-read vectors, a
//   readback scoreboard against a local result model, and hand-written
//   sequences for load, run completion, protocol errors and mid-run reset.
module tb_lbp_image_host;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16384;

    logic              clk;
    logic              reset;
    logic              start;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;
    logic              done;
    logic [ADDR_W:0]   wr_cnt;
    logic              proto_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    lbp_image_host #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .gray_ready(gray_ready),
        .gray_req  (gray_req),
        .gray_addr (gray_addr),
        .gray_data (gray_data),
        .lbp_valid (lbp_valid),
        .lbp_addr  (lbp_addr),
        .lbp_data  (lbp_data),
        .finish    (finish),
        .done      (done),
        .wr_cnt    (wr_cnt),
        .proto_err (proto_err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] res_m [0:DEPTH-1];
    logic [DATA_W-1:0] sb_q [$];

    typedef struct {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } gray_vec_t;

    gray_vec_t gv [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] code_of(input int a);
        logic [31:0] t;
        t = a * 7 + 3;
        return t[DATA_W-1:0];
    endfunction

    task automatic lbp_write(input int a, input logic [DATA_W-1:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = ADDR_W'(a);
        lbp_data  = d;
        res_m[a]  = d;
        tick();
        lbp_valid = 1'b0;
    endtask

    // Expected readback is queued when the address is driven and compared
    // when the registered rd_data appears a cycle later.
    task automatic rd_check(input string name, input int a);
        rd_addr = ADDR_W'(a);
        sb_q.push_back(res_m[a]);
        tick();
        chk(name, 32'(rd_data), 32'(sb_q.pop_front()));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic single_load(input int a);
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_addr  = ADDR_W'(a);
        ld_data  = DATA_W'(a);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_last   = 1'b0;
        gray_req  = 1'b0;
        gray_addr = '0;
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        lbp_data  = '0;
        finish    = 1'b0;
        rd_addr   = '0;

        gv[0] = '{1'b1, 14'd129,   8'h81};
        gv[1] = '{1'b0, 14'd129,   8'h00};
        gv[2] = '{1'b1, 14'd16383, 8'hFF};
        gv[3] = '{1'b0, 14'd16383, 8'h00};
        gv[4] = '{1'b1, 14'd0,     8'h00};
        gv[5] = '{1'b1, 14'd255,   8'hFF};
        gv[6] = '{1'b1, 14'd256,   8'h00};
        gv[7] = '{1'b1, 14'h1234,  8'h34};

        #1;
        chk("rst_gray_ready", 32'(gray_ready), 32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_wr_cnt",     32'(wr_cnt),     32'd0);
        chk("rst_proto_err",  32'(proto_err),  32'd0);
        chk("rst_rd_data",    32'(rd_data),    32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Run 1: full image load, img[a] = a[7:0].
        pulse_start();
        chk("load_gray_ready_low", 32'(gray_ready), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            ld_valid = 1'b1;
            ld_addr  = ADDR_W'(a);
            ld_data  = DATA_W'(a);
            ld_last  = (a == DEPTH - 1);
            if (a == DEPTH - 1) begin
                chk("gray_ready_before_last", 32'(gray_ready), 32'd0);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("gray_ready_after_load", 32'(gray_ready), 32'd1);

        foreach (gv[i]) begin
            gray_req  = gv[i].req;
            gray_addr = gv[i].addr;
            #1;
            chk($sformatf("gray_vec%0d", i), 32'(gray_data), 32'(gv[i].exp));
            tick();
        end
        gray_req = 1'b0;

        // Full engine run over the 126x126 interior.
        for (int y = 1; y < 127; y++) begin
            for (int x = 1; x < 127; x++) begin
                lbp_write(y * 128 + x, code_of(y * 128 + x));
            end
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("run1_done",       32'(done),       32'd1);
        chk("run1_gray_ready", 32'(gray_ready), 32'd0);
        chk("run1_wr_cnt",     32'(wr_cnt),     32'd15876);
        chk("run1_proto_err",  32'(proto_err),  32'd0);
        rd_check("rb_129",   129);
        rd_check("rb_130",   130);
        rd_check("rb_16254", 16254);
        rd_check("rb_8000",  8000);

        // Run 2: duplicate writes and lbp_valid together with finish.
        pulse_start();
        chk("run2_done_clr",   32'(done),   32'd0);
        chk("run2_wr_cnt_clr", 32'(wr_cnt), 32'd0);
        single_load(5);
        chk("run2_gray_ready", 32'(gray_ready), 32'd1);
        lbp_write(201, 8'h11);
        lbp_write(201, 8'h22);
        lbp_valid = 1'b1;
        finish    = 1'b1;
        lbp_addr  = 14'd200;
        lbp_data  = 8'h5A;
        res_m[200] = 8'h5A;
        tick();
        lbp_valid = 1'b0;
        finish    = 1'b0;
        chk("run2_done",       32'(done),       32'd1);
        chk("run2_wr_cnt",     32'(wr_cnt),     32'd3);
        chk("run2_gray_ready", 32'(gray_ready), 32'd0);
        rd_check("rb2_200", 200);
        rd_check("rb2_201", 201);
        rd_check("rb2_129_prev", 129);

        // Result write in DONE is a violation with no write and no count.
        lbp_valid = 1'b1;
        lbp_addr  = 14'd130;
        lbp_data  = 8'hEE;
        tick();
        lbp_valid = 1'b0;
        chk("done_viol_err",    32'(proto_err), 32'd1);
        chk("done_viol_wr_cnt", 32'(wr_cnt),    32'd3);
        rd_check("rb_130_kept", 130);

        // Run 3: reset in the middle of SERVE.
        pulse_start();
        chk("run3_err_clr", 32'(proto_err), 32'd0);
        single_load(7);
        lbp_write(300, 8'h33);
        lbp_write(301, 8'h44);
        chk("run3_wr_cnt", 32'(wr_cnt), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_gray_ready", 32'(gray_ready), 32'd0);
        chk("midrst_wr_cnt",     32'(wr_cnt),     32'd0);
        chk("midrst_done",       32'(done),       32'd0);
        chk("midrst_rd_data",    32'(rd_data),    32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Result write in IDLE.
        lbp_valid = 1'b1;
        lbp_addr  = 14'd129;
        lbp_data  = 8'hEE;
        tick();
        lbp_valid = 1'b0;
        chk("idle_viol_err",    32'(proto_err), 32'd1);
        chk("idle_viol_wr_cnt", 32'(wr_cnt),    32'd0);
        rd_check("rb_129_idle", 129);
        rd_check("rb_301", 301);
        pulse_start();
        chk("run4_err_clr", 32'(proto_err), 32'd0);

        // Image survives reset; start and ld_valid in SERVE are ignored.
        single_load(0);
        chk("run4_gray_ready", 32'(gray_ready), 32'd1);
        pulse_start();
        chk("serve_start_err",   32'(proto_err),  32'd1);
        chk("serve_start_ready", 32'(gray_ready), 32'd1);
        ld_valid = 1'b1;
        ld_addr  = 14'd129;
        ld_data  = 8'h00;
        tick();
        ld_valid  = 1'b0;
        gray_req  = 1'b1;
        gray_addr = 14'd129;
        #1;
        chk("img_survives", 32'(gray_data), 32'h81);
        gray_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
